// File: rtl/crc_pkg.sv
// ============================================================================
// Module      : crc_pkg
// Description : Shared CRC-8 constants, FSM encoding and single-step LFSR update
// Revision    : 1.0
// ============================================================================
`default_nettype none

package crc_pkg;

    localparam int          CRC_W    = 8;
    localparam logic [7:0]  CRC_SEED = 8'hD8;
    localparam logic [7:0]  CRC_TAPS = 8'hC4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } crc_state_t;

    // Right shift with feedback injected into bits 7, 6 and 2.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] lfsr,
                                                  input logic             din);
        logic fb;
        fb = din ^ lfsr[0];
        return (lfsr >> 1) ^ (fb ? CRC_TAPS : '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc_bit_cnt.sv
// ============================================================================
// Module      : crc_bit_cnt
// Description : 3-bit CRC bit counter with clear/increment and last-bit flag
// Revision    : 1.0
// ============================================================================
`default_nettype none

module crc_bit_cnt (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [2:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 3'd0;
        end else if (clr) begin
            r_cnt <= 3'd0;
        end else if (inc) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign last = inc && (r_cnt == 3'd7);

endmodule

`default_nettype wire

// File: rtl/crc_checker.sv
// ============================================================================
// Module      : crc_checker
// Description : Serial CRC-8 receive checker, one pass/fail pulse per frame.
//               Optional err_cnt port enabled by CRC_CHK_ERRCNT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module crc_checker
    import crc_pkg::*;
#(
    parameter logic [7:0] SEED = CRC_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data,
    input  logic       active,
    input  logic       crc_bit,
    input  logic       crc_valid,
    output logic       busy,
    output logic       done,
    output logic       crc_ok,
    output logic       crc_err
`ifdef CRC_CHK_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    crc_state_t       r_state, w_state_nxt;
    logic [CRC_W-1:0] r_lfsr, w_lfsr_nxt;
    logic             r_mis, w_mis_nxt;
    logic             r_done, r_ok, r_err;
    logic             w_done_nxt, w_ok_nxt, w_err_nxt;
    logic             w_clr, w_inc, w_last;

    crc_bit_cnt u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .inc  (w_inc),
        .last (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_lfsr  <= SEED;
            r_mis   <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_mis   <= w_mis_nxt;
            r_done  <= w_done_nxt;
            r_ok    <= w_ok_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_mis_nxt   = r_mis;
        w_done_nxt  = 1'b0;
        w_ok_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (active) begin
                    w_lfsr_nxt  = crc_step(SEED, data);
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (active) begin
                    w_lfsr_nxt = crc_step(r_lfsr, data);
                end else begin
                    w_state_nxt = ST_CHECK;
                    w_clr       = 1'b1;
                    w_mis_nxt   = 1'b0;
                end
            end
            ST_CHECK: begin
                // A new message arriving mid-check aborts and starts the next frame.
                if (active) begin
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_lfsr_nxt  = crc_step(SEED, data);
                    w_state_nxt = ST_DATA;
                end else if (crc_valid) begin
                    w_mis_nxt  = r_mis | (crc_bit ^ r_lfsr[0]);
                    w_lfsr_nxt = {r_lfsr[CRC_W-1], r_lfsr[CRC_W-1:1]};
                    w_inc      = 1'b1;
                    if (w_last) begin
                        w_done_nxt  = 1'b1;
                        w_ok_nxt    = ~w_mis_nxt;
                        w_err_nxt   = w_mis_nxt;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef CRC_CHK_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign crc_ok  = r_ok;
    assign crc_err = r_err;

endmodule

`default_nettype wire
